// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction-fetch front end with an in-order prefetch queue.
//
// Issues sequential word-aligned fetch requests to a pipelined, in-order
// memory port, buffers the returned words together with their PC, and hands
// them to decode over a valid/ready handshake. A trap or branch redirect
// flushes the queue and marks every response still in flight as stale.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   branch, branch_vec         branch redirect and its target
//   trap, trap_vec             trap redirect and its target (wins over branch)
//   req_valid/req_addr/req_ready     fetch request channel
//   resp_valid/resp_data             in-order fetch response channel
//   out_valid/out_ready              decode handshake
//   out_pc/out_next_pc/out_instr     head instruction, its PC and PC+4
module fetch_prefetch #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        branch,
    input  logic [31:0] branch_vec,
    input  logic        trap,
    input  logic [31:0] trap_vec,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        resp_valid,
    input  logic [31:0] resp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_next_pc,
    output logic [31:0] out_instr
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CXW = CW + 1;
    localparam int PW  = $clog2(DEPTH);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CXW-1:0] DEPTH_X = CXW'(DEPTH);

    logic          redirect;
    logic [31:0]   target;
    logic          req_fire;
    logic          push;
    logic          pop;
    logic [CXW-1:0] credits_used;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_pc_q [DEPTH];
    logic [31:0]   fifo_pc_d [DEPTH];
    logic [31:0]   fifo_instr_q [DEPTH];
    logic [31:0]   fifo_instr_d [DEPTH];

    always_comb begin
        redirect = trap | branch;
        target   = (trap ? trap_vec : branch_vec) & ~32'h0000_0003;

        // Entries already promised to the queue: live in-flight requests
        // (stale ones will never be pushed) plus what is buffered.
        credits_used = {1'b0, outstanding_q} - {1'b0, drop_q} + {1'b0, count_q};

        req_valid = !reset && !redirect && (outstanding_q < DEPTH_C)
                    && (credits_used < DEPTH_X);
        req_addr  = pc_q;
        req_fire  = req_valid && req_ready;

        out_valid   = (count_q != '0) && !redirect;
        pop         = out_valid && out_ready;
        push        = resp_valid && (drop_q == '0) && !redirect;
        out_pc      = fifo_pc_q[rd_ptr_q];
        out_instr   = fifo_instr_q[rd_ptr_q];
        out_next_pc = out_pc + 32'd4;
    end

    always_comb begin
        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        drop_d        = drop_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_valid);

        if (redirect) begin
            pc_d      = target;
            resp_pc_d = target;
            // Everything still owed by memory is stale; a response landing
            // this very cycle is already being thrown away.
            drop_d    = outstanding_q - CW'(resp_valid);
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (resp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                fifo_pc_d[wr_ptr_q]    = resp_pc_q;
                fifo_instr_d[wr_ptr_q] = resp_data;
                wr_ptr_d               = wr_ptr_q + PW'(1);
                resp_pc_d              = resp_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_VECTOR;
            resp_pc_q     <= RESET_VECTOR;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // Queue storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        fifo_pc_q    <= fifo_pc_d;
        fifo_instr_q <= fifo_instr_d;
    end

    resp_without_request: assert property (
        @(posedge clk) disable iff (reset) !(resp_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_prefetch.sv
module tb_fetch_prefetch;

    localparam logic [31:0] RV    = 32'hFFFF_FFF8;
    localparam int          DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        branch;
    logic [31:0] branch_vec;
    logic        trap;
    logic [31:0] trap_vec;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;
    logic [31:0] out_instr;

    fetch_prefetch #(.RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .branch      (branch),
        .branch_vec  (branch_vec),
        .trap        (trap),
        .trap_vec    (trap_vec),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_next_pc (out_next_pc),
        .out_instr   (out_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model state and scoreboard.
    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mreq_t;

    typedef struct {
        bit          trap;
        bit          branch;
        logic [31:0] tvec;
        logic [31:0] bvec;
        int          lat;
        int          pre;
        logic [31:0] exp_addr;
    } redir_vec_t;

    mreq_t       pend[$];
    logic [31:0] sbq[$];
    logic [31:0] popped_q[$];
    int          avail;
    logic [31:0] exp_pc;
    int          cyc;
    int          lat;
    int          acc_cnt;
    int          checks;
    int          errors;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock cycle. Called at a falling edge after the caller has set the
    // control inputs; returns at the next falling edge.
    task automatic step();
        bit          rv;
        bit          redir;
        bit          exp_rv;
        bit          acc;
        bit          pop;
        mreq_t       r;
        logic [31:0] e;
        rv         = !reset && (pend.size() != 0) && (pend[0].due <= cyc);
        resp_valid = rv;
        resp_data  = rv ? mem_word(pend[0].addr) : $urandom;
        #1;
        redir = trap | branch;
        if (reset) begin
            check("req_valid_in_reset", {31'd0, req_valid}, 32'd0);
        end else begin
            exp_rv = !redir && (pend.size() < DEPTH) && (sbq.size() < DEPTH);
            check("req_valid", {31'd0, req_valid}, {31'd0, exp_rv});
            check("out_valid", {31'd0, out_valid}, {31'd0, (avail != 0) && !redir});
            if (req_valid) check("req_addr", req_addr, exp_pc);
        end
        acc = !reset && req_valid && req_ready;
        pop = !reset && out_valid && out_ready;
        if (pop) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop actual=%h required=none", out_pc);
            end else begin
                e = sbq.pop_front();
                check("out_pc", out_pc, e);
                check("out_next_pc", out_next_pc, e + 32'd4);
                check("out_instr", out_instr, mem_word(e));
                popped_q.push_back(out_pc);
                avail--;
            end
        end
        if (rv) begin
            r = pend.pop_front();
            if (!r.stale) avail++;
        end
        if (acc) begin
            pend.push_back('{addr: req_addr, due: cyc + lat, stale: 1'b0});
            sbq.push_back(req_addr);
            exp_pc = exp_pc + 32'd4;
            acc_cnt++;
        end
        if (redir && !reset) begin
            sbq.delete();
            avail = 0;
            foreach (pend[i]) pend[i].stale = 1'b1;
            exp_pc = (trap ? trap_vec : branch_vec) & ~32'h0000_0003;
        end
        if (reset) begin
            pend.delete();
            sbq.delete();
            avail  = 0;
            exp_pc = RV;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic expect_pops(input string name, input logic [31:0] first,
                               input int n, input int bound);
        int k;
        k = 0;
        popped_q.delete();
        while (popped_q.size() < n && k < bound) begin
            step();
            k++;
        end
        if (popped_q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: pops=%0d required=%0d", name, popped_q.size(), n);
        end else begin
            for (int j = 0; j < n; j++) check(name, popped_q[j], first + 32'(4 * j));
        end
    endtask

    task automatic redirect_to(input bit t, input bit b, input logic [31:0] tv,
                               input logic [31:0] bv);
        trap       = t;
        branch     = b;
        trap_vec   = tv;
        branch_vec = bv;
        step();
        trap   = 1'b0;
        branch = 1'b0;
    endtask

    redir_vec_t vt[5];

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{trap: 1'b0, branch: 1'b1, tvec: 32'h0, bvec: 32'h100,
                  lat: 2, pre: 3, exp_addr: 32'h100};
        vt[1] = '{trap: 1'b1, branch: 1'b1, tvec: 32'h80, bvec: 32'h200,
                  lat: 1, pre: 4, exp_addr: 32'h80};
        vt[2] = '{trap: 1'b0, branch: 1'b1, tvec: 32'h0, bvec: 32'h1002,
                  lat: 3, pre: 5, exp_addr: 32'h1000};
        vt[3] = '{trap: 1'b1, branch: 1'b0, tvec: 32'h43, bvec: 32'h700,
                  lat: 1, pre: 2, exp_addr: 32'h40};
        vt[4] = '{trap: 1'b1, branch: 1'b0, tvec: 32'hFFFF_FFFE, bvec: 32'h0,
                  lat: 2, pre: 6, exp_addr: 32'hFFFF_FFFC};

        checks = 0; errors = 0; cyc = 0; avail = 0; acc_cnt = 0;
        lat = 1; exp_pc = RV;
        reset = 1'b1; branch = 1'b0; trap = 1'b0;
        branch_vec = '0; trap_vec = '0;
        req_ready = 1'b1; out_ready = 1'b1;
        resp_valid = 1'b0; resp_data = '0;

        @(negedge clk);
        run(2);
        reset = 1'b0;
        #1;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_req_valid", {31'd0, req_valid}, 32'd1);
        check("reset_req_addr", req_addr, RV);

        // Sequential stream across the 2^32 wrap.
        expect_pops("stream", RV, 8, 30);

        // Redirect table.
        for (int i = 0; i < 5; i++) begin
            lat = vt[i].lat;
            run(vt[i].pre);
            trap       = vt[i].trap;
            branch     = vt[i].branch;
            trap_vec   = vt[i].tvec;
            branch_vec = vt[i].bvec;
            #1;
            check("tbl_redir_out_valid", {31'd0, out_valid}, 32'd0);
            check("tbl_redir_req_valid", {31'd0, req_valid}, 32'd0);
            step();
            trap   = 1'b0;
            branch = 1'b0;
            #1;
            check("tbl_req_valid", {31'd0, req_valid}, 32'd1);
            check("tbl_req_addr", req_addr, vt[i].exp_addr);
            expect_pops("tbl_first_pcs", vt[i].exp_addr, 2, 30);
        end

        // Backpressure: queue fills to DEPTH and no further.
        lat = 1;
        out_ready = 1'b0;
        redirect_to(1'b0, 1'b1, 32'h0, 32'h2000);
        acc_cnt = 0;
        run(10);
        check("bp_accepts", acc_cnt, DEPTH);
        check("bp_req_valid_full", {31'd0, req_valid}, 32'd0);
        out_ready = 1'b1;
        expect_pops("bp_drain", 32'h2000, 4, 10);

        // Redirect with three requests in flight.
        req_ready = 1'b0;
        run(10);
        lat = 4;
        redirect_to(1'b0, 1'b1, 32'h0, 32'h3000);
        req_ready = 1'b1;
        run(3);
        req_ready = 1'b0;
        redirect_to(1'b0, 1'b1, 32'h0, 32'h100);
        req_ready = 1'b1;
        expect_pops("inflight_redirect", 32'h100, 2, 40);

        // Response coinciding with a misaligned branch.
        req_ready = 1'b0;
        run(10);
        lat = 2;
        redirect_to(1'b0, 1'b1, 32'h0, 32'h4000);
        req_ready = 1'b1;
        run(2);
        redirect_to(1'b0, 1'b1, 32'h0, 32'h1002);
        expect_pops("resp_on_redirect", 32'h1000, 2, 20);

        // Mid-run reset.
        lat = 1;
        run(6);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        check("midreset_req_valid", {31'd0, req_valid}, 32'd1);
        check("midreset_req_addr", req_addr, RV);
        expect_pops("post_reset", RV, 3, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
